phase_diff_averager: RTL and testbench
======================================

// Module: phase_diff_averager
// PURPOSE
//  Consumes the {magnitude, phase} stream from the Cartesian-to-polar CORDIC stage.
//  Forms the lagged phase difference ph[n] - ph[n-LAG] and averages 2**LOG2_LEN such differences.
//  Emits one mean phase step per window; the result is the coarse carrier-frequency-offset estimate
//  (LAG=16 matches the 802.11 short training period) for the downstream derotator.
// PARAMETERS
//  WIDTH     32  magnitude/phase word width; phase full scale 2**WIDTH == 2*pi (signed, +-pi at +-2**(WIDTH-1))
//  LAG       16  sample lag of the phase difference; >= 1
//  LOG2_LEN  5   log2 of the number of differences averaged per estimate; >= 0
// PORTS
//  clk      in   1        clock
//  reset    in   1        synchronous, active-high reset
//  s_valid  in   1        input sample valid
//  s_ready  out  1        input sample accepted when s_valid && s_ready
//  s_data   in   2*WIDTH  {mag[2*WIDTH-1:WIDTH], phase[WIDTH-1:0]}; mag is ignored
//  m_valid  out  1        estimate valid
//  m_ready  in   1        estimate consumed when m_valid && m_ready
//  m_data   out  WIDTH    signed mean phase advance over LAG samples, same scaling as input phase
// BEHAVIOUR
//  - Reset (sync, clk): state=FILL, fill count=0, diff count=0, acc=0, m_valid=0, m_data=0, s_ready=1.
//    Delay-line contents are don't-care.
//  - Delay line: LAG-entry shift register of phases, shifted only on an input handshake.
//  - States:
//    FILL : accept LAG samples into the delay line; no differences are formed. After the LAG-th
//           handshake -> ACCUM.
//    ACCUM: on each handshake, diff = phase - dly[LAG-1] computed in WIDTH bits (modulo 2**WIDTH,
//           so +-pi wrap is natural). acc += sign-extended diff, with acc WIDTH+LOG2_LEN bits signed
//           (cannot overflow). The same handshake shifts the delay line. On the 2**LOG2_LEN-th diff,
//           m_data <= acc_next >>> LOG2_LEN (arithmetic shift, floor); m_valid<=1; acc<=0;
//           count<=0; -> HOLD.
//    HOLD : s_ready=0; m_data/m_valid held stable. On m_ready -> m_valid<=0, -> ACCUM.
//           The delay line stays primed, so FILL is not revisited.
//  - s_ready = (state != HOLD), registered/derived from state only; it never depends on s_valid.
//    It does not depend combinationally on m_ready. Consequently, one bubble cycle occurs per estimate.
//  - Latency: m_valid rises the cycle after the completing input handshake.
//    The first estimate needs LAG + 2**LOG2_LEN input samples; each later estimate needs 2**LOG2_LEN.
//  - s_valid low cycles: no state change; accumulation resumes on the next handshake.
//  - Averaging is linear on wrapped diffs: result is correct while all diffs in a window lie in
//    the same half-plane. Diffs straddling +-pi produce a biased mean (accepted, documented limitation).
//  - Reset mid-window discards the partial accumulation and the delay line; the block restarts in FILL.
//  - AXI-style rules: m_data stable while m_valid && !m_ready; m_valid never drops without m_ready.
// TESTING
//  (all with WIDTH=16, LAG=4, LOG2_LEN=3 unless noted)
//  1 constant phase 0x1234, s_valid=1, m_ready=1 -> first m_valid after 12th handshake (next cycle),
//    m_data=0x0000; repeats every 8 accepted samples + 1 bubble.
//  2 phase ramp +0x0100/sample -> m_data=0x0400 for every estimate.
//  3 phase ramp +0x3000/sample (wraps) -> diff=0xC000 each -> m_data=0xC000 (-pi/2).
//  4 ramp +0x0100 with m_ready low 5 cycles at first m_valid -> s_ready=0 and m_data/m_valid stable
//    for 5 cycles; after release the next estimate is 0x0400 with no sample lost/duplicated
//    (scoreboard on sample indices).
//  5 diffs alternating 0x0003/0x0004 (phase steps chosen accordingly) -> acc=28, m_data=28>>>3=0x0003;
//    negated sequence -> acc=-28 -> m_data=0xFFFC (floor).
//  6 reset asserted after 6 diffs in ACCUM -> next cycle m_valid=0, s_ready=1; the following estimate
//    requires LAG+8 fresh samples and ignores pre-reset data.
//  Bench checks m_data stability under backpressure and random s_valid/m_ready gaps (1000 samples)
//  against a reference model.

Source files
------------

// File: rtl/phase_diff_averager.sv
// Lagged phase-difference averager: mean of 2**LOG2_LEN wrapped differences ph[n]-ph[n-LAG],
// emitted once per window as the coarse carrier-frequency-offset estimate.
module phase_diff_averager #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned LAG      = 16,
    parameter int unsigned LOG2_LEN = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [2*WIDTH-1:0]   s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data
);
    localparam int unsigned AW    = WIDTH + LOG2_LEN;
    localparam int unsigned FCW   = $clog2(LAG + 1);
    localparam int unsigned DCW   = LOG2_LEN + 1;
    localparam int unsigned NDIFF = 1 << LOG2_LEN;

    typedef enum logic [1:0] {FILL, ACCUM, HOLD} state_t;

    state_t                state, state_n;
    logic [FCW-1:0]        fill_cnt, fill_cnt_n;
    logic [DCW-1:0]        diff_cnt, diff_cnt_n;
    logic signed [AW-1:0]  acc, acc_n, acc_sum, diff_ext;
    logic [WIDTH-1:0]      m_data_n, phase, diff;
    logic                  m_valid_n, accept;
    logic [WIDTH-1:0]      dly [LAG];
    logic                  unused_mag;

    assign unused_mag = ^s_data[2*WIDTH-1:WIDTH];
    assign phase      = s_data[WIDTH-1:0];
    assign accept     = s_valid && s_ready;
    // Modulo-2**WIDTH subtraction gives the natural +-pi wrap.
    assign diff       = phase - dly[LAG-1];
    assign diff_ext   = AW'($signed(diff));
    assign acc_sum    = acc + diff_ext;

    // Next-state and datapath decode.
    always_comb begin
        state_n    = state;
        fill_cnt_n = fill_cnt;
        diff_cnt_n = diff_cnt;
        acc_n      = acc;
        m_valid_n  = m_valid;
        m_data_n   = m_data;
        case (state)
            FILL: begin
                if (accept) begin
                    fill_cnt_n = fill_cnt + FCW'(1);
                    if (fill_cnt == FCW'(LAG - 1)) begin
                        state_n = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (diff_cnt == DCW'(NDIFF - 1)) begin
                        m_data_n   = WIDTH'(acc_sum >>> LOG2_LEN);
                        m_valid_n  = 1'b1;
                        acc_n      = '0;
                        diff_cnt_n = '0;
                        state_n    = HOLD;
                    end else begin
                        acc_n      = acc_sum;
                        diff_cnt_n = diff_cnt + DCW'(1);
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    m_valid_n = 1'b0;
                    state_n   = ACCUM;
                end
            end
            default: begin
                state_n = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FILL;
            fill_cnt <= '0;
            diff_cnt <= '0;
            acc      <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            s_ready  <= 1'b1;
        end else begin
            state    <= state_n;
            fill_cnt <= fill_cnt_n;
            diff_cnt <= diff_cnt_n;
            acc      <= acc_n;
            m_valid  <= m_valid_n;
            m_data   <= m_data_n;
            s_ready  <= (state_n != HOLD);
        end
    end

    // Delay line contents need no reset; FILL re-primes it.
    always_ff @(posedge clk) begin
        if (accept) begin
            dly[0] <= phase;
            for (int unsigned i = 1; i < LAG; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end
endmodule

// File: tb/tb_phase_diff_averager.sv
// Self-checking bench for phase_diff_averager (WIDTH=16, LAG=4, LOG2_LEN=3).
module tb_phase_diff_averager;
    localparam int unsigned WIDTH    = 16;
    localparam int unsigned LAG      = 4;
    localparam int unsigned LOG2_LEN = 3;
    localparam int          NWIN     = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [2*WIDTH-1:0] s_data = '0;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic [WIDTH-1:0]   m_data;

    phase_diff_averager #(.WIDTH(WIDTH), .LAG(LAG), .LOG2_LEN(LOG2_LEN)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: history of accepted phases, expected estimates, observations.
    int hist[$];
    int exp_q[$];
    int obs_q[$];
    int rise_q[$];
    int win_sum = 0;
    int win_n   = 0;
    int acc_cnt = 0;
    bit prev_hold = 0;
    bit prev_mv = 0;
    int prev_data = 0;
    logic [WIDTH-1:0] ph_arr[$];

    function automatic int floor_div8(input int s);
        return (s < 0) ? -((-s + NWIN - 1) / NWIN) : s / NWIN;
    endfunction

    function automatic void model_push(input int ph);
        int d;
        if (hist.size() == LAG) begin
            d = (ph - hist[0]) & 32'hFFFF;
            if (d >= 32768) d -= 65536;
            win_sum += d;
            win_n++;
            void'(hist.pop_front());
            if (win_n == NWIN) begin
                exp_q.push_back(floor_div8(win_sum) & 32'hFFFF);
                win_sum = 0;
                win_n = 0;
            end
        end
        hist.push_back(ph);
    endfunction

    // Monitor: sampled on the falling edge, where all handshake signals are settled.
    always @(negedge clk) begin
        if (reset) begin
            hist.delete();
            exp_q.delete();
            win_sum = 0;
            win_n = 0;
            acc_cnt = 0;
            prev_hold = 0;
            prev_mv = 0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", int'(m_valid), 1);
                chk("hold_data", int'(m_data), prev_data);
            end
            if (m_valid && !prev_mv) rise_q.push_back(acc_cnt);
            if (m_valid && s_ready) chk("bubble_s_ready", 1, 0);
            if (s_valid && s_ready) begin
                model_push(int'(s_data[WIDTH-1:0]));
                acc_cnt++;
            end
            if (m_valid && m_ready) begin
                obs_q.push_back(int'(m_data));
                if (exp_q.size() == 0) chk("unexpected_estimate", int'(m_data), -1);
                else chk("model_estimate", int'(m_data), exp_q.pop_front());
            end
            prev_hold = m_valid && !m_ready;
            prev_data = int'(m_data);
            prev_mv = m_valid;
        end
    end

    task automatic drive(input int idx, input int nsamp, input int pv, input int pr);
        s_valid = (idx < nsamp) && ($urandom_range(99) < pv);
        s_data  = {WIDTH'($urandom), (idx < nsamp) ? ph_arr[idx] : WIDTH'(0)};
        m_ready = ($urandom_range(99) < pr);
    endtask

    task automatic step(inout int idx, input int nsamp, input int pv, input int pr);
        bit hs;
        @(negedge clk);
        hs = s_valid && s_ready;
        @(posedge clk);
        #1;
        if (hs) idx++;
        drive(idx, nsamp, pv, pr);
    endtask

    task automatic run_to(inout int idx, input int nsamp, input int pv, input int pr);
        int cyc = 0;
        drive(idx, nsamp, pv, pr);
        while (idx < nsamp && cyc < 20000) begin
            step(idx, nsamp, pv, pr);
            cyc++;
        end
        if (idx < nsamp) chk("run_timeout", idx, nsamp);
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        while ((exp_q.size() != 0 || m_valid) && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        obs_q.delete();
        rise_q.delete();
    endtask

    // Phase generator: first LAG phases step by k0, then ph[n] = ph[n-LAG] + (even n ? da : db).
    task automatic build(input int nsamp, input int start, input int k0, input int da, input int db);
        ph_arr.delete();
        for (int n = 0; n < nsamp; n++) begin
            if (n < LAG) ph_arr.push_back(WIDTH'(start + n * k0));
            else ph_arr.push_back(ph_arr[n - LAG] + WIDTH'((n % 2 == 0) ? da : db));
        end
    endtask

    typedef struct {
        int start;
        int k0;
        int da;
        int db;
        int exp_data;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int idx;
        int cyc;
        int held;
        vecs[0] = '{32'h1234, 0,       0,       0,       32'h0000};
        vecs[1] = '{0,        32'h0100, 32'h0400, 32'h0400, 32'h0400};
        vecs[2] = '{0,        32'h3000, 32'hC000, 32'hC000, 32'hC000};
        vecs[3] = '{7,        5,        3,        4,        32'h0003};
        vecs[4] = '{7,        5,        32'hFFFD, 32'hFFFC, 32'hFFFC};

        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("reset_m_valid", int'(m_valid), 0);
        chk("reset_s_ready", int'(s_ready), 1);
        chk("reset_m_data", int'(m_data), 0);

        // Table-driven windows with full throughput.
        for (int t = 0; t < 5; t++) begin
            do_reset();
            build(LAG + 3 * NWIN, vecs[t].start, vecs[t].k0, vecs[t].da, vecs[t].db);
            idx = 0;
            run_to(idx, LAG + 3 * NWIN, 100, 100);
            drain();
            chk($sformatf("vec%0d_count", t), obs_q.size(), 3);
            foreach (obs_q[i]) chk($sformatf("vec%0d_data%0d", t, i), obs_q[i], vecs[t].exp_data);
            chk($sformatf("vec%0d_rises", t), rise_q.size(), 3);
            foreach (rise_q[i]) chk($sformatf("vec%0d_rise%0d", t, i), rise_q[i], LAG + NWIN * (i + 1));
        end

        // Backpressure at the first estimate: held stable for 5 cycles, nothing lost.
        do_reset();
        build(LAG + 2 * NWIN, 32'h0055, 32'h0100, 32'h0400, 32'h0400);
        idx = 0;
        cyc = 0;
        drive(idx, LAG + 2 * NWIN, 100, 0);
        while (!m_valid && cyc < 100) begin
            step(idx, LAG + 2 * NWIN, 100, 0);
            cyc++;
        end
        chk("bp_first_idx", idx, LAG + NWIN);
        for (held = 0; held < 5; held++) begin
            chk("bp_s_ready", int'(s_ready), 0);
            chk("bp_m_valid", int'(m_valid), 1);
            chk("bp_m_data", int'(m_data), 32'h0400);
            @(posedge clk);
            #1;
        end
        run_to(idx, LAG + 2 * NWIN, 100, 100);
        drain();
        chk("bp_count", obs_q.size(), 2);
        foreach (obs_q[i]) chk("bp_data", obs_q[i], 32'h0400);

        // Reset after 6 diffs: stale window discarded, refill required.
        do_reset();
        build(LAG + 6, 32'h7777, 32'h0100, 32'h0400, 32'h0400);
        idx = 0;
        run_to(idx, LAG + 6, 100, 100);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_mid_m_valid", int'(m_valid), 0);
        chk("rst_mid_s_ready", int'(s_ready), 1);
        obs_q.delete();
        rise_q.delete();
        build(LAG + NWIN, 0, 32'h0200, 32'h0800, 32'h0800);
        idx = 0;
        run_to(idx, LAG + NWIN, 100, 100);
        drain();
        chk("rst_mid_count", obs_q.size(), 1);
        if (obs_q.size() > 0) chk("rst_mid_data", obs_q[0], 32'h0800);
        if (rise_q.size() > 0) chk("rst_mid_rise", rise_q[0], LAG + NWIN);

        // Random phases with random gaps on both sides.
        do_reset();
        ph_arr.delete();
        for (int n = 0; n < 1000; n++) ph_arr.push_back(WIDTH'($urandom));
        idx = 0;
        run_to(idx, 1000, 70, 60);
        drain();
        chk("rand_count", obs_q.size(), (1000 - LAG) / NWIN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
